// File: rtl/compress_stream_packer.sv
// compress_stream_packer: packs left-packed compressed beats into dense full-width vectors
module compress_stream_packer #(
    parameter int VECTOR_SIZE = 8,
    parameter int DATA_WIDTH = 64,
    localparam int CW = $clog2(VECTOR_SIZE + 1)
) (
    input  logic                              clock,
    input  logic                              resetn,
    input  logic                              ivalid,
    output logic                              oready,
    input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] datain,
    input  logic [CW-1:0]                     countin,
    input  logic                              flushin,
    output logic                              ovalid,
    input  logic                              iready,
    output logic [VECTOR_SIZE*DATA_WIDTH-1:0] dataout,
    output logic [CW-1:0]                     outcount,
    output logic                              olast
);
    localparam int V = VECTOR_SIZE;
    localparam int W = DATA_WIDTH;
    localparam logic [CW-1:0] VC = CW'(V);
    localparam logic [CW:0] VT = (CW+1)'(V);
    typedef enum logic {RUN, TAIL} state_t;
    state_t state, state_nx;
    logic [CW-1:0] fill, cnt;
    logic [CW:0] total;
    logic [(V-1)*W-1:0] res;
    logic [(2*V-1)*W-1:0] win;
    logic free, accept, full;
    assign free = !ovalid || iready;
    assign oready = state == RUN && free;
    assign accept = ivalid && oready;
    assign cnt = countin > VC ? VC : countin;
    assign total = {1'b0, fill} + {1'b0, cnt};
    assign full = total >= VT;
    // window lanes past total stay zero, so partial beats and residual need no extra masking
    always_comb begin
        win = '0;
        for (int i = 0; i < 2*V-1; i++)
            if (i < int'(fill)) win[i*W +: W] = res[i*W +: W];
            else if (i < int'(total)) win[i*W +: W] = datain[(i - int'(fill))*W +: W];
    end
    always_comb begin
        state_nx = state == TAIL ? (free ? RUN : TAIL) : (accept && flushin && total > VT ? TAIL : RUN);
    end
    always_ff @(posedge clock) begin
        state <= resetn ? state_nx : RUN;
    end
    always_ff @(posedge clock) begin
        if (!resetn) begin
            ovalid <= 1'b0;
            dataout <= '0;
            outcount <= '0;
            olast <= 1'b0;
            fill <= '0;
            res <= '0;
        end else if (state == TAIL && free) begin
            ovalid <= 1'b1;
            dataout <= {{W{1'b0}}, res};
            outcount <= fill;
            olast <= 1'b1;
            fill <= '0;
        end else if (accept && (full || flushin)) begin
            ovalid <= 1'b1;
            dataout <= win[V*W-1:0];
            outcount <= full ? VC : CW'(total);
            olast <= flushin && total <= VT;
            fill <= full ? CW'(total - VT) : '0;
            res <= full ? win[(2*V-1)*W-1:V*W] : '0;
        end else begin
            if (ovalid && iready) ovalid <= 1'b0;
            if (accept) begin
                res <= win[(V-1)*W-1:0];
                fill <= CW'(total);
            end
        end
    end
endmodule

// File: tb/tb_compress_stream_packer.sv
// tb_compress_stream_packer: directed checks of lane packing, flush, backpressure and reset
module tb_compress_stream_packer;
    localparam int V = 8;
    localparam int W = 64;
    localparam int CW = 4;
    logic clock = 1'b0;
    logic resetn, ivalid, iready, flushin, oready, ovalid, olast;
    logic [V*W-1:0] datain, dataout;
    logic [CW-1:0] countin, outcount;
    int checks = 0;
    int failures = 0;
    int xfers = 0;
    int x0;
    always #5 clock = ~clock;
    compress_stream_packer #(.VECTOR_SIZE(V), .DATA_WIDTH(W)) dut (
        .clock(clock), .resetn(resetn), .ivalid(ivalid), .oready(oready),
        .datain(datain), .countin(countin), .flushin(flushin), .ovalid(ovalid),
        .iready(iready), .dataout(dataout), .outcount(outcount), .olast(olast)
    );
    always @(posedge clock) if (resetn && ovalid && iready) xfers <= xfers + 1;
    function automatic logic [V*W-1:0] lanes(int g, int s, int n);
        logic [V*W-1:0] r = '0;
        for (int i = 0; i < n; i++) r[i*W +: W] = W'(g*256 + s + i);
        return r;
    endfunction
    task automatic chk(string tag, logic [V*W-1:0] obs, logic [V*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic chkb(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic out(string tag, logic v, logic [V*W-1:0] d, int c, logic l);
        chkb({tag, "_ovalid"}, 32'(ovalid), 32'(v));
        chk({tag, "_data"}, dataout, d);
        chkb({tag, "_count"}, 32'(outcount), c);
        chkb({tag, "_olast"}, 32'(olast), 32'(l));
    endtask
    task automatic step;
        @(posedge clock);
        #1;
    endtask
    task automatic drive(logic v, logic [V*W-1:0] d, int c, logic f);
        ivalid = v;
        datain = d;
        countin = CW'(c);
        flushin = f;
    endtask
    initial begin
        resetn = 1'b0;
        iready = 1'b1;
        drive(0, '0, 0, 0);
        step;
        step;
        out("reset", 0, '0, 0, 0);
        resetn = 1'b1;
        chkb("reset_oready", 32'(oready), 1);
        drive(1, lanes(10, 0, 3), 3, 0);
        step;
        chkb("t1_a_ovalid", 32'(ovalid), 0);
        drive(1, lanes(11, 0, 3), 3, 0);
        step;
        chkb("t1_b_ovalid", 32'(ovalid), 0);
        drive(1, lanes(12, 0, 3), 3, 0);
        step;
        out("t1_full", 1, lanes(10, 0, 3) | (lanes(11, 0, 3) << (3*W)) | (lanes(12, 0, 2) << (6*W)), 8, 0);
        drive(1, '0, 0, 1);
        step;
        out("t1_tail", 1, lanes(12, 2, 1), 1, 1);
        drive(0, '0, 0, 0);
        step;
        chkb("t1_idle", 32'(ovalid), 0);
        drive(1, lanes(20, 0, 8), 8, 0);
        step;
        out("t2_pass", 1, lanes(20, 0, 8), 8, 0);
        drive(1, '0, 0, 1);
        step;
        out("t4_empty_flush", 1, '0, 0, 1);
        drive(1, lanes(21, 0, 8), 0, 0);
        step;
        chkb("zero_cnt_ovalid", 32'(ovalid), 0);
        drive(1, '0, 0, 1);
        step;
        out("zero_cnt_flush", 1, '0, 0, 1);
        drive(0, '0, 0, 0);
        step;
        drive(1, lanes(30, 0, 5), 5, 0);
        step;
        chkb("t3_fill_ovalid", 32'(ovalid), 0);
        drive(1, lanes(31, 0, 6), 6, 1);
        step;
        out("t3_full", 1, lanes(30, 0, 5) | (lanes(31, 0, 3) << (5*W)), 8, 0);
        chkb("t3_tail_oready", 32'(oready), 0);
        drive(0, '0, 0, 0);
        step;
        out("t3_tail", 1, lanes(31, 3, 3), 3, 1);
        chkb("t3_oready_back", 32'(oready), 1);
        step;
        chkb("t3_idle", 32'(ovalid), 0);
        drive(1, lanes(40, 0, 8), 9, 0);
        step;
        out("clamp", 1, lanes(40, 0, 8), 8, 0);
        drive(1, '0, 0, 1);
        step;
        out("clamp_fill0", 1, '0, 0, 1);
        drive(0, '0, 0, 0);
        step;
        iready = 1'b0;
        x0 = xfers;
        drive(1, lanes(50, 0, 8), 8, 0);
        step;
        out("t5_first", 1, lanes(50, 0, 8), 8, 0);
        drive(1, lanes(51, 0, 8), 8, 0);
        for (int i = 0; i < 5; i++) begin
            step;
            out("t5_hold", 1, lanes(50, 0, 8), 8, 0);
            chkb("t5_oready", 32'(oready), 0);
        end
        iready = 1'b1;
        step;
        out("t5_next", 1, lanes(51, 0, 8), 8, 0);
        drive(0, '0, 0, 0);
        step;
        chkb("t5_idle", 32'(ovalid), 0);
        chkb("t5_xfers", xfers - x0, 2);
        drive(1, lanes(60, 0, 4), 4, 0);
        step;
        chkb("t6_fill_ovalid", 32'(ovalid), 0);
        iready = 1'b0;
        drive(1, lanes(61, 0, 8), 8, 0);
        step;
        out("t6_pre", 1, lanes(60, 0, 4) | (lanes(61, 0, 4) << (4*W)), 8, 0);
        resetn = 1'b0;
        drive(0, '0, 0, 0);
        step;
        chkb("t6_rst_ovalid", 32'(ovalid), 0);
        chkb("t6_rst_count", 32'(outcount), 0);
        resetn = 1'b1;
        iready = 1'b1;
        drive(1, lanes(62, 0, 2), 2, 1);
        step;
        out("t6_new", 1, lanes(62, 0, 2), 2, 1);
        drive(0, '0, 0, 0);
        step;
        chkb("t6_idle", 32'(ovalid), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
